// File: rtl/ibus_rr_arb_pkg.sv
// Shared types and helpers for the instruction-bus round-robin arbiter.
package ibus_rr_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ibus_rr_arb_rr_pick.sv
// Rotating-priority picker: first requester at index >= ptr, wrapping mod N.
module ibus_rr_arb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  // Walk the ring starting at ptr and take the first active request.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/ibus_rr_arb.sv
// N-port round-robin read arbiter in front of a single read-only Wishbone slave.
// A grant is held for one whole slave cycle; priority rotates past the served
// master whether the cycle ended by ack, master abort or watchdog error.
//
// state | meaning
// IDLE  | no slave cycle; picks the next requester from ptr
// BUSY  | grant held, x_cyc follows the granted master's m_cyc
module ibus_rr_arb
  import ibus_rr_arb_pkg::*;
#(
  parameter int          N       = 4,
  parameter int          AW      = 32,
  parameter int          DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic [N-1:0]    m_cyc,
  input  logic [N*AW-1:0] m_adr,
  output logic [N-1:0]    m_ack,
  output logic [N-1:0]    m_err,
  output logic [DW-1:0]   m_rdt,
  output logic            x_cyc,
  output logic [AW-1:0]   x_adr,
  input  logic            x_ack,
  input  logic [DW-1:0]   x_rdt,
  output logic [N-1:0]    grant,
  output logic            busy
);

  localparam int PW = $clog2(N);
  localparam int WW = cnt_width(TIMEOUT);
  // Last count before the watchdog fires; only meaningful when TIMEOUT > 0.
  localparam logic [WW-1:0] WDOG_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WW-1:0] WDOG_MAX  = WW'(TIMEOUT);

  arb_state_e    state_q;
  logic [N-1:0]  grant_q;
  logic [PW-1:0] gidx_q;
  logic [PW-1:0] ptr_q;
  logic [WW-1:0] wdog_q;
  logic [N-1:0]  err_q;

  logic [N-1:0]  pick_gnt;
  logic [PW-1:0] pick_idx;
  logic          pick_any;

  logic          in_busy;
  logic          ack_hit;
  logic          wdog_fire;
  logic [PW-1:0] ptr_nxt;

  ibus_rr_arb_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req_i (m_cyc),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Slave-side muxing and zero-latency ack return, all from the registered grant.
  always_comb begin
    in_busy   = (state_q == ST_BUSY);
    x_cyc     = in_busy & m_cyc[gidx_q];
    x_adr     = in_busy ? m_adr[gidx_q*AW +: AW] : '0;
    ack_hit   = x_cyc & x_ack;
    m_ack     = ack_hit ? grant_q : '0;
    m_err     = err_q;
    m_rdt     = x_rdt;
    grant     = grant_q;
    busy      = x_cyc;
    wdog_fire = (TIMEOUT != 0) && x_cyc && !x_ack && (wdog_q == WDOG_LAST);
    ptr_nxt   = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + 1'b1;
  end

  // Arbitration FSM with grant, pointer, watchdog and error-pulse registers.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
      err_q   <= '0;
    end else begin
      err_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_gnt;
            gidx_q  <= pick_idx;
            wdog_q  <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Ack, master abort (x_cyc low) and timeout all close the cycle the
          // same way; ack has precedence because wdog_fire excludes x_ack.
          if (!x_cyc || ack_hit || wdog_fire) begin
            if (wdog_fire) err_q <= grant_q;
            grant_q <= '0;
            ptr_q   <= ptr_nxt;
            wdog_q  <= '0;
            state_q <= ST_IDLE;
          end else if (wdog_q != WDOG_MAX) begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: begin
          grant_q <= '0;
          wdog_q  <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibus_rr_arb.sv
// Directed bench for the round-robin read arbiter (N=4, TIMEOUT=4).
module tb_ibus_rr_arb;

  localparam int          N  = 4;
  localparam int          AW = 32;
  localparam int          DW = 32;
  localparam int unsigned TO = 4;

  logic            wb_clk = 1'b0;
  logic            wb_rst_n;
  logic [N-1:0]    m_cyc;
  logic [N*AW-1:0] m_adr;
  logic [N-1:0]    m_ack;
  logic [N-1:0]    m_err;
  logic [DW-1:0]   m_rdt;
  logic            x_cyc;
  logic [AW-1:0]   x_adr;
  logic            x_ack;
  logic [DW-1:0]   x_rdt;
  logic [N-1:0]    grant;
  logic            busy;

  int n_chk = 0;
  int n_err = 0;

  ibus_rr_arb #(
    .N       (N),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .m_cyc    (m_cyc),
    .m_adr    (m_adr),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_rdt    (m_rdt),
    .x_cyc    (x_cyc),
    .x_adr    (x_adr),
    .x_ack    (x_ack),
    .x_rdt    (x_rdt),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge wb_clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int gcount;
    int gap;
    int exp_idx;

    wb_rst_n = 1'b0;
    m_cyc    = '0;
    x_ack    = 1'b0;
    x_rdt    = '0;
    for (int i = 0; i < N; i++) m_adr[i*AW +: AW] = AW'(i * 256);

    // Reset state
    #3;
    check("rst_x_cyc", x_cyc, 0);
    check("rst_grant", grant, 0);
    check("rst_m_ack", m_ack, 0);
    check("rst_m_err", m_err, 0);
    check("rst_busy",  busy,  0);
    check("rst_x_adr", x_adr, 0);
    tick();
    tick();
    wb_rst_n = 1'b1;

    // Single master 1, slave acks two cycles after x_cyc
    tick();
    m_cyc = 4'b0010;
    #1;
    check("s1_idle_grant", grant, 0);
    tick();
    #1;
    check("s1_grant", grant, 4'b0010);
    check("s1_x_cyc", x_cyc, 1);
    check("s1_x_adr", x_adr, 32'h100);
    check("s1_busy",  busy,  1);
    check("s1_no_ack", m_ack, 0);
    tick();
    #1;
    check("s1_wait_ack", m_ack, 0);
    tick();
    x_ack = 1'b1;
    x_rdt = 32'hDEAD_BEEF;
    #1;
    check("s1_ack",  m_ack, 4'b0010);
    check("s1_rdt",  m_rdt, 32'hDEAD_BEEF);
    check("s1_err0", m_err, 0);
    tick();
    x_ack = 1'b0;
    m_cyc = '0;
    #1;
    check("s1_grant_clr", grant, 0);
    check("s1_x_cyc_clr", x_cyc, 0);

    // ptr=2 now: masters 0 and 3 together -> 3 first, then 0
    tick();
    m_cyc = 4'b1001;
    #1;
    check("p2_idle", grant, 0);
    tick();
    #1;
    check("p2_grant3", grant, 4'b1000);
    check("p2_adr3",   x_adr, 32'h300);
    x_ack = 1'b1;
    #1;
    check("p2_ack3", m_ack, 4'b1000);
    tick();
    x_ack = 1'b0;
    m_cyc = 4'b0001;
    #1;
    check("p2_gap", x_cyc, 0);
    tick();
    #1;
    check("p2_grant0", grant, 4'b0001);
    x_ack = 1'b1;
    #1;
    check("p2_ack0", m_ack, 4'b0001);
    tick();
    x_ack = 1'b0;
    m_cyc = 4'b0100;

    // Reset in the middle of a BUSY cycle
    tick();
    #1;
    check("mr_grant2", grant, 4'b0100);
    check("mr_x_cyc",  x_cyc, 1);
    x_ack = 1'b1;
    #1;
    check("mr_ack_pre", m_ack, 4'b0100);
    wb_rst_n = 1'b0;
    m_cyc    = 4'b1111;
    #1;
    check("mr_x_cyc0", x_cyc, 0);
    check("mr_grant0", grant, 0);
    check("mr_m_ack0", m_ack, 0);
    check("mr_m_err0", m_err, 0);
    check("mr_busy0",  busy,  0);
    tick();
    x_ack    = 1'b0;
    wb_rst_n = 1'b1;

    // All four requesting, slave acks whenever x_cyc is high: 0,1,2,3,0
    gcount  = 0;
    gap     = 0;
    exp_idx = 0;
    for (int cyc = 0; cyc < 40 && gcount < 5; cyc++) begin
      tick();
      x_ack = 1'b0;
      #1;
      if (x_cyc) begin
        check("rr_grant", grant, 64'(1) << exp_idx);
        check("rr_adr", x_adr, 64'(exp_idx * 256));
        if (gcount > 0) check("rr_gap", gap >= 1, 1);
        x_ack = 1'b1;
        #1;
        check("rr_ack", m_ack, 64'(1) << exp_idx);
        gcount++;
        exp_idx = (exp_idx + 1) % N;
        gap = 0;
      end else begin
        gap++;
      end
    end
    check("rr_count", gcount, 5);

    // ptr=1: masters 0 and 2 request, slave never acks master 2 -> watchdog
    tick();
    x_ack = 1'b0;
    m_cyc = 4'b0101;
    tick();
    #1;
    check("wd_grant2", grant, 4'b0100);
    check("wd_x_cyc",  x_cyc, 1);
    for (int c = 1; c < 4; c++) begin
      tick();
      #1;
      check("wd_no_err_early", m_err, 0);
      check("wd_still_busy", x_cyc, 1);
    end
    tick();
    #1;
    check("wd_err2",   m_err, 4'b0100);
    check("wd_x_cyc0", x_cyc, 0);
    check("wd_grant0", grant, 0);
    check("wd_no_ack", m_ack, 0);
    m_cyc = 4'b0001;
    tick();
    #1;
    check("wd_next_grant", grant, 4'b0001);
    check("wd_err_once",   m_err, 0);

    // Ack on the timeout cycle wins over the watchdog
    tick();
    tick();
    tick();
    x_ack = 1'b1;
    #1;
    check("to_ack",  m_ack, 4'b0001);
    check("to_err0", m_err, 0);
    tick();
    x_ack = 1'b0;
    m_cyc = '0;
    #1;
    check("to_err_after", m_err, 0);
    check("to_grant_clr", grant, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
